shift_pipe: RTL

Parametrised, pipelined barrel shifter for the processor execute stage; it succeeds the fixed-amount shift primitives. Accepts one operand, shift amount, operation and tag per cycle over a valid/ready handshake. Produces SLL, SRL, SRA or ROR results after a fixed latency of one register stage per shift-amount bit. A single global stall provides backpressure.

---
 rtl/shift_pkg.sv | 12 +
 rtl/shift_stage.sv | 32 +++
 rtl/shift_pipe.sv | 118 +++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings
// and the width of the op field.
package shift_pkg;

  localparam int unsigned SHIFT_OP_W = 2;

  localparam logic [SHIFT_OP_W-1:0] SHIFT_OP_SLL = 2'b00;
  localparam logic [SHIFT_OP_W-1:0] SHIFT_OP_SRL = 2'b01;
  localparam logic [SHIFT_OP_W-1:0] SHIFT_OP_SRA = 2'b10;
  localparam logic [SHIFT_OP_W-1:0] SHIFT_OP_ROR = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One combinational stage of the barrel shifter: shifts by the fixed amount
// AMT when enabled, otherwise passes the data through.
// Optional feature: SHIFT_PIPE_ROTATE_EN enables rotate-right for op 11;
// without it op 11 is a logical right shift.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT   = 1
) (
  input  logic [WIDTH-1:0]      data,
  input  logic [SHIFT_OP_W-1:0] op,
  input  logic                  en,
  output logic [WIDTH-1:0]      result
);

  // Select the shifted form of the data for this stage's fixed amount.
  always_comb begin
    result = data;
    if (en) begin
      case (op)
        SHIFT_OP_SLL: result = data << AMT;
        SHIFT_OP_SRA: result = $signed(data) >>> AMT;
`ifdef SHIFT_PIPE_ROTATE_EN
        SHIFT_OP_ROR: result = {data[AMT-1:0], data[WIDTH-1:AMT]};
`endif
        default:      result = data >> AMT;
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, stage k
// shifting by 2^k. A single global stall (output valid but not taken)
// freezes every stage.
// Optional feature: SHIFT_PIPE_ROTATE_EN (see shift_stage) enables ROR.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned TAG_W   = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SHAMT_W-1:0]    in_shamt,
  input  logic [SHIFT_OP_W-1:0] in_op,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [TAG_W-1:0]      out_tag
);

  localparam int unsigned NS = SHAMT_W;

  // Per-stage state. Op and remaining shamt are only needed by the stages
  // that still have a shift to perform, so the last stage omits them.
  logic                  valid_q [NS];
  logic [WIDTH-1:0]      data_q  [NS];
  logic [TAG_W-1:0]      tag_q   [NS];
  logic [SHIFT_OP_W-1:0] op_q    [NS-1];
  logic [SHAMT_W-1:0]    sh_q    [NS-1];

  logic [NS-1:0][WIDTH-1:0] shifted;
  logic                     stall;

  // Output drive and global stall / ready.
  always_comb begin
    out_valid = valid_q[NS-1];
    out_data  = data_q[NS-1];
    out_tag   = tag_q[NS-1];
    stall     = out_valid & ~out_ready;
    in_ready  = ~stall;
  end

  for (genvar k = 0; k < NS; k++) begin : g_stage
    logic [WIDTH-1:0]      din;
    logic [SHIFT_OP_W-1:0] dop;
    logic                  den;

    if (k == 0) begin : g_first
      // Stage 0 shifts the incoming operand directly.
      always_comb begin
        din = in_data;
        dop = in_op;
        den = in_shamt[0];
      end
    end else if (k == NS - 1) begin : g_last
      // Remaining shamt is shifted down each stage, so by now only the top
      // original bit can be non-zero; the OR equals bit 0.
      always_comb begin
        din = data_q[k-1];
        dop = op_q[k-1];
        den = |sh_q[k-1];
      end
    end else begin : g_mid
      // Middle stages take bit 0 of the remaining shamt.
      always_comb begin
        din = data_q[k-1];
        dop = op_q[k-1];
        den = sh_q[k-1][0];
      end
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .AMT   (1 << k)
    ) u_shift (
      .data   (din),
      .op     (dop),
      .en     (den),
      .result (shifted[k])
    );
  end

  // Stage registers: clear on reset, hold on stall, otherwise advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NS; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
        tag_q[i]   <= '0;
      end
      for (int unsigned i = 0; i < NS - 1; i++) begin
        op_q[i] <= '0;
        sh_q[i] <= '0;
      end
    end else if (!stall) begin
      valid_q[0] <= in_valid;
      data_q[0]  <= shifted[0];
      tag_q[0]   <= in_tag;
      op_q[0]    <= in_op;
      sh_q[0]    <= in_shamt >> 1;
      for (int unsigned i = 1; i < NS; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= shifted[i];
        tag_q[i]   <= tag_q[i-1];
      end
      for (int unsigned i = 1; i < NS - 1; i++) begin
        op_q[i] <= op_q[i-1];
        sh_q[i] <= sh_q[i-1] >> 1;
      end
    end
  end

endmodule
